// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: seven bus cycles that push PC and P, then
// fetch the selected vector and hand it back as a one-cycle PC load.
module interrupt_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        src_reset,
  input  logic        src_nmi,
  input  logic        src_brk,
  input  logic        src_irq,
  input  logic        nmi_pend,
  input  logic [15:0] pc_in,
  input  logic [7:0]  p_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  din,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  output logic        we,
  output logic        sp_dec,
  output logic        set_i,
  output logic [15:0] pc_out,
  output logic        pc_load,
  output logic        busy,
  output logic        done,
  output logic        nmi_clr,
  output logic        int_clr
);

  // IDLE takes the eighth code so that S6 + 1 lands on it naturally.
  typedef enum logic [2:0] {
    ST_S0   = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_S4   = 3'd4,
    ST_S5   = 3'd5,
    ST_S6   = 3'd6,
    ST_IDLE = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    SRC_IRQ   = 2'd0,
    SRC_BRK   = 2'd1,
    SRC_NMI   = 2'd2,
    SRC_RESET = 2'd3
  } src_t;

  state_t      state_q, state_d;
  src_t        src_q, src_d;
  src_t        src_sel;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  p_q, p_d;
  logic [7:0]  sp_q, sp_d;
  logic        hijack_q, hijack_d;
  logic [7:0]  vec_lo_q, vec_lo_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic        done_q, done_d;

  logic        vec_nmi;
  logic [15:0] vec_base;
  logic        maskable;

  // Source priority: reset > nmi > brk > irq; nothing flagged falls back to irq.
  always_comb begin
    casez ({src_reset, src_nmi, src_brk, src_irq})
      4'b1???: src_sel = SRC_RESET;
      4'b01??: src_sel = SRC_NMI;
      4'b001?: src_sel = SRC_BRK;
      default: src_sel = SRC_IRQ;
    endcase
  end

  // Vector selection; a maskable source is redirected to the NMI vector once hijacked.
  always_comb begin
    maskable = (src_q == SRC_IRQ) || (src_q == SRC_BRK);
    vec_nmi  = (src_q == SRC_NMI) || (maskable && hijack_q);
    if (vec_nmi)
      vec_base = 16'hFFFA;
    else if (src_q == SRC_RESET)
      vec_base = 16'hFFFC;
    else
      vec_base = 16'hFFFE;
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    pc_d     = pc_q;
    p_d      = p_q;
    sp_d     = sp_q;
    hijack_d = hijack_q;
    vec_lo_d = vec_lo_q;
    pc_out_d = pc_out_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_S0;
          pc_d     = pc_in;
          p_d      = p_in;
          sp_d     = sp_in;
          src_d    = src_sel;
          hijack_d = 1'b0;
        end
      end
      ST_S0, ST_S1: begin
        state_d = state_t'(state_q + 3'd1);
        if (nmi_pend && maskable) hijack_d = 1'b1;
      end
      ST_S2, ST_S3, ST_S4: begin
        state_d = state_t'(state_q + 3'd1);
        sp_d    = sp_q - 8'd1;
        if (nmi_pend && maskable) hijack_d = 1'b1;
      end
      ST_S5: begin
        state_d  = ST_S6;
        vec_lo_d = din;
      end
      ST_S6: begin
        state_d  = ST_IDLE;
        pc_out_d = {din, vec_lo_q};
        done_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      src_q    <= SRC_IRQ;
      pc_q     <= 16'h0000;
      p_q      <= 8'h00;
      sp_q     <= 8'h00;
      hijack_q <= 1'b0;
      vec_lo_q <= 8'h00;
      pc_out_q <= 16'h0000;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      pc_q     <= pc_d;
      p_q      <= p_d;
      sp_q     <= sp_d;
      hijack_q <= hijack_d;
      vec_lo_q <= vec_lo_d;
      pc_out_q <= pc_out_d;
      done_q   <= done_d;
    end
  end

  // Bus and strobe outputs decoded from the current state.
  always_comb begin
    addr    = 16'h0000;
    dout    = 8'h00;
    we      = 1'b0;
    sp_dec  = 1'b0;
    set_i   = 1'b0;
    nmi_clr = 1'b0;
    int_clr = 1'b0;
    busy    = (state_q != ST_IDLE);
    done    = done_q;
    pc_load = done_q;
    pc_out  = pc_out_q;
    case (state_q)
      ST_S0, ST_S1: addr = pc_q;
      ST_S2: begin
        addr   = {8'h01, sp_q};
        dout   = pc_q[15:8];
        we     = (src_q != SRC_RESET);
        sp_dec = 1'b1;
      end
      ST_S3: begin
        addr   = {8'h01, sp_q};
        dout   = pc_q[7:0];
        we     = (src_q != SRC_RESET);
        sp_dec = 1'b1;
      end
      ST_S4: begin
        addr   = {8'h01, sp_q};
        dout   = {p_q[7:6], 1'b1, (src_q == SRC_BRK), p_q[3:0]};
        we     = (src_q != SRC_RESET);
        sp_dec = 1'b1;
      end
      ST_S5: begin
        addr    = vec_base;
        set_i   = 1'b1;
        nmi_clr = vec_nmi;
      end
      ST_S6: begin
        addr    = vec_base + 16'd1;
        int_clr = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Testbench for interrupt_sequencer: directed scenarios plus randomized
// sequences checked cycle by cycle against a bus-transaction model.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, src_reset, src_nmi, src_brk, src_irq, nmi_pend;
  logic [15:0] pc_in;
  logic [7:0]  p_in, sp_in, din;
  logic [15:0] addr, pc_out;
  logic [7:0]  dout;
  logic        we, sp_dec, set_i, pc_load, busy, done, nmi_clr, int_clr;

  int n_tests = 0;
  int n_fail  = 0;

  // Vector ROM at FFFA..FFFF, indexed by the low three address bits.
  logic [7:0] vec_mem [0:7];

  // Model state for the sequence being checked.
  logic [15:0] m_pc;
  logic [7:0]  m_p, m_sp;
  logic [3:0]  m_bits;     // {reset, nmi, brk, irq}
  logic [6:0]  m_pend;     // nmi_pend value driven during S0..S6
  int          m_src;      // 3 reset, 2 nmi, 1 brk, 0 irq
  logic [15:0] m_base;
  logic [15:0] exp_pc_out;

  always #5 clk = ~clk;

  always_comb begin
    din = 8'hEE;
    if (addr[15:3] == 13'h1FFF && addr[2:0] >= 3'd2) din = vec_mem[addr[2:0]];
  end

  interrupt_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .src_reset(src_reset), .src_nmi(src_nmi), .src_brk(src_brk), .src_irq(src_irq),
    .nmi_pend(nmi_pend), .pc_in(pc_in), .p_in(p_in), .sp_in(sp_in), .din(din),
    .addr(addr), .dout(dout), .we(we), .sp_dec(sp_dec), .set_i(set_i),
    .pc_out(pc_out), .pc_load(pc_load), .busy(busy), .done(done),
    .nmi_clr(nmi_clr), .int_clr(int_clr)
  );

  task automatic randomize_vectors();
    for (int i = 0; i < 8; i++) vec_mem[i] = 8'($urandom);
  endtask

  // Drive the model inputs and derive the expected source and vector.
  task automatic apply_inputs();
    bit hijack;
    pc_in     = m_pc;
    p_in      = m_p;
    sp_in     = m_sp;
    src_reset = m_bits[3];
    src_nmi   = m_bits[2];
    src_brk   = m_bits[1];
    src_irq   = m_bits[0];
    nmi_pend  = 1'b0;
    if (m_bits[3])      m_src = 3;
    else if (m_bits[2]) m_src = 2;
    else if (m_bits[1]) m_src = 1;
    else                m_src = 0;
    hijack = (m_src <= 1) && (m_pend[4:0] != 5'd0);
    if (m_src == 2 || hijack) m_base = 16'hFFFA;
    else if (m_src == 3)      m_base = 16'hFFFC;
    else                      m_base = 16'hFFFE;
  endtask

  // Called between edges; start is sampled at the next rising edge.
  task automatic begin_seq(input bit hold);
    apply_inputs();
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Walk S0..S6 and the done cycle, checking every output against the model.
  task automatic check_seq(input string name);
    logic [15:0] ea;
    logic [7:0]  ed, ef, af;
    logic [7:0]  spk, lo_idx, hi_idx;
    bit          chk_d;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ea = 16'h0000; ed = 8'h00; ef = 8'h00; chk_d = 1'b0;
      // flag order: busy done pc_load we sp_dec set_i nmi_clr int_clr
      if (k < 2) begin
        ea = m_pc;
        ef = 8'b1000_0000;
      end else if (k < 5) begin
        spk   = m_sp - 8'(k - 2);
        ea    = {8'h01, spk};
        chk_d = 1'b1;
        if (k == 2)      ed = m_pc[15:8];
        else if (k == 3) ed = m_pc[7:0];
        else             ed = {m_p[7:6], 1'b1, (m_src == 1), m_p[3:0]};
        ef = {1'b1, 2'b00, (m_src != 3), 1'b1, 3'b000};
      end else if (k == 5) begin
        ea = m_base;
        ef = {1'b1, 4'b0000, 1'b1, (m_base == 16'hFFFA), 1'b0};
      end else if (k == 6) begin
        ea = m_base + 16'd1;
        ef = 8'b1000_0001;
      end else begin
        lo_idx     = {5'd0, m_base[2:0]};
        hi_idx     = {5'd0, m_base[2:0] + 3'd1};
        exp_pc_out = {vec_mem[hi_idx[2:0]], vec_mem[lo_idx[2:0]]};
        ef         = 8'b0110_0000;
      end
      af = {busy, done, pc_load, we, sp_dec, set_i, nmi_clr, int_clr};
      n_tests++;
      if (af !== ef) begin
        n_fail++;
        $display("FAIL %s cyc%0d flags got %b want %b", name, k, af, ef);
      end
      n_tests++;
      if (addr !== ea) begin
        n_fail++;
        $display("FAIL %s cyc%0d addr got %h want %h", name, k, addr, ea);
      end
      if (chk_d) begin
        n_tests++;
        if (dout !== ed) begin
          n_fail++;
          $display("FAIL %s cyc%0d dout got %h want %h", name, k, dout, ed);
        end
      end
      n_tests++;
      if (pc_out !== exp_pc_out) begin
        n_fail++;
        $display("FAIL %s cyc%0d pc_out got %h want %h", name, k, pc_out, exp_pc_out);
      end
      // Disturb inputs mid-sequence: only the values latched at start may matter.
      if (k < 7) begin
        nmi_pend  = m_pend[k];
        pc_in     = 16'($urandom);
        p_in      = 8'($urandom);
        sp_in     = 8'($urandom);
        src_reset = 1'($urandom);
        src_nmi   = 1'($urandom);
        src_brk   = 1'($urandom);
        src_irq   = 1'($urandom);
      end else begin
        nmi_pend = 1'b0;
      end
    end
    $display("[TB] %s src=%0d pc=%h sp=%h base=%h pc_out=%h", name, m_src, m_pc, m_sp, m_base, pc_out);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, done, pc_load, we, sp_dec, set_i, nmi_clr, int_clr} !== 8'h00 ||
        addr !== 16'h0000 || dout !== 8'h00 || pc_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_outputs got busy=%b done=%b addr=%h dout=%h pc_out=%h want all 0",
               busy, done, addr, dout, pc_out);
    end
    start = 1'b0;
    rst = 1'b0;
    exp_pc_out = 16'h0000;
    $display("[TB] test_reset done");
  endtask

  task automatic test_irq();
    randomize_vectors();
    vec_mem[6] = 8'h34;
    vec_mem[7] = 8'h12;
    m_pc = 16'hC123; m_p = 8'h20; m_sp = 8'hFD; m_bits = 4'b0001; m_pend = 7'd0;
    @(negedge clk);
    begin_seq(1'b0);
    check_seq("irq");
    n_tests++;
    if (pc_out !== 16'h1234) begin
      n_fail++;
      $display("FAIL irq_vector got %h want 1234", pc_out);
    end
  endtask

  task automatic test_brk_hijack();
    randomize_vectors();
    m_pc = 16'h8000; m_p = 8'h00; m_sp = 8'hFF; m_bits = 4'b0010; m_pend = 7'b0001000;
    @(negedge clk);
    begin_seq(1'b0);
    check_seq("brk_hijack");
    n_tests++;
    if (pc_out !== {vec_mem[3], vec_mem[2]}) begin
      n_fail++;
      $display("FAIL brk_hijack_vector got %h want %h", pc_out, {vec_mem[3], vec_mem[2]});
    end
  endtask

  task automatic test_reset_source();
    randomize_vectors();
    m_pc = 16'h1234; m_p = 8'hFF; m_sp = 8'h00; m_bits = 4'b1111; m_pend = 7'b1111111;
    @(negedge clk);
    begin_seq(1'b0);
    check_seq("reset_src");
    n_tests++;
    if (pc_out !== {vec_mem[5], vec_mem[4]}) begin
      n_fail++;
      $display("FAIL reset_src_vector got %h want %h", pc_out, {vec_mem[5], vec_mem[4]});
    end
  endtask

  task automatic test_rst_abort();
    randomize_vectors();
    m_pc = 16'hABCD; m_p = 8'h55; m_sp = 8'h80; m_bits = 4'b0100; m_pend = 7'd0;
    @(negedge clk);
    begin_seq(1'b0);
    repeat (4) @(negedge clk);          // now in S3
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({busy, done, pc_load, we, sp_dec, set_i, nmi_clr, int_clr} !== 8'h00 ||
        addr !== 16'h0000 || dout !== 8'h00 || pc_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_abort_outputs got busy=%b we=%b addr=%h dout=%h pc_out=%h want all 0",
               busy, we, addr, dout, pc_out);
    end
    rst = 1'b0;
    exp_pc_out = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if ({busy, done, pc_load, nmi_clr, int_clr} !== 5'b0) begin
        n_fail++;
        $display("FAIL rst_abort_quiet cyc%0d got busy=%b done=%b pc_load=%b clr=%b%b want 0",
                 i, busy, done, pc_load, nmi_clr, int_clr);
      end
    end
    $display("[TB] test_rst_abort done");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      randomize_vectors();
      m_pc = 16'($urandom); m_p = 8'($urandom); m_sp = 8'($urandom);
      m_bits = 4'(1 << s); m_pend = 7'd0;
      begin_seq(1'b1);
      check_seq("back_to_back");
    end
    start = 1'b0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      randomize_vectors();
      m_pc   = 16'($urandom);
      m_p    = 8'($urandom);
      m_sp   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      m_bits = 4'($urandom);
      if ($urandom_range(0, 2) == 0) m_bits = 4'd0;
      m_pend = 7'd0;
      if ($urandom_range(0, 1) == 1) m_pend[$urandom_range(0, 6)] = 1'b1;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      begin_seq(1'b0);
      check_seq("random");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; nmi_pend = 1'b0;
    src_reset = 1'b0; src_nmi = 1'b0; src_brk = 1'b0; src_irq = 1'b0;
    pc_in = 16'h0000; p_in = 8'h00; sp_in = 8'h00;
    exp_pc_out = 16'h0000;
    for (int i = 0; i < 8; i++) vec_mem[i] = 8'h00;
    test_reset();
    test_irq();
    test_brk_hijack();
    test_reset_source();
    test_rst_abort();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
